// File: rtl/multi_channel_batch_buffer_if.sv
// multi_channel_batch_buffer_if: sample-in / batch-out streaming bundle.
//   sink_valid, sink_ready, sink_data    : multi-channel A2D capture port (channel c at [c*DATA_WIDTH +: DATA_WIDTH])
//   source_ready, source_valid, source_sop, source_eop, source_channel, source_data : FFT batch stream
//   modport slave is the buffer's view, modport master is the surrounding logic's view.
interface multi_channel_batch_buffer_if #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 14
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic                           sink_valid;
    logic                           sink_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] sink_data;
    logic                           source_ready;
    logic                           source_valid;
    logic                           source_sop;
    logic                           source_eop;
    logic [CW-1:0]                  source_channel;
    logic [DATA_WIDTH-1:0]          source_data;
    modport slave (
        input  sink_valid, sink_data, source_ready,
        output sink_ready, source_valid, source_sop, source_eop, source_channel, source_data
    );
    modport master (
        output sink_valid, sink_data, source_ready,
        input  sink_ready, source_valid, source_sop, source_eop, source_channel, source_data
    );
endinterface

// File: rtl/multi_channel_batch_buffer.sv
// multi_channel_batch_buffer: captures a TOT-sample window from every channel, then replays it as
// RUNS overlapping batches per channel (each shifted by STEP) in run-major, channel, sample order.
//   clk, reset     : single clock, asynchronous active-high reset
//   start          : arms a capture from IDLE
//   continuous     : re-arm LOAD after the final beat instead of returning to IDLE
//   busy, done     : not-IDLE flag, one-cycle pulse after the final accepted beat
//   bus            : sink/source streaming signals (slave modport)
module multi_channel_batch_buffer #(
    parameter int BATCH_SIZE = 2048,
    parameter int RUNS       = 3,
    parameter int STEP       = 1,
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    output logic                         busy,
    output logic                         done,
    multi_channel_batch_buffer_if.slave  bus
);
    localparam int TOT = BATCH_SIZE + (RUNS - 1) * STEP;
    localparam int RW  = RUNS > 1 ? $clog2(RUNS) : 1;
    localparam int CW  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int IW  = $clog2(BATCH_SIZE);
    localparam int WW  = $clog2(TOT);
    localparam int AW  = WW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
    state_t state, state_nx;

    logic [CHANNELS*DATA_WIDTH-1:0] mem [TOT];
    logic [CHANNELS*DATA_WIDTH-1:0] row;
    logic [WW-1:0]                  wr_addr;
    logic [AW-1:0]                  rd_addr;
    logic [RW-1:0]                  run;
    logic [CW-1:0]                  chan;
    logic [IW-1:0]                  idx;
    logic [CW-1:0]                  ch;
    logic [DATA_WIDTH-1:0]          dat;
    logic vld, sop, eop, issued_all, last_out;
    logic sink_fire, wr_last, idx_last, chan_last, run_last, final_issue, adv, issue, fin;

    assign sink_fire   = bus.sink_valid && state == LOAD;
    assign wr_last     = wr_addr == WW'(TOT - 1);
    assign idx_last    = idx == IW'(BATCH_SIZE - 1);
    assign chan_last   = chan == CW'(CHANNELS - 1);
    assign run_last    = run == RW'(RUNS - 1);
    assign final_issue = idx_last && chan_last && run_last;
    // The output register doubles as the memory's registered read port: it only
    // loads when empty or when its current beat is being accepted.
    assign adv         = state == EMIT && (!vld || bus.source_ready);
    assign issue       = adv && !issued_all;
    assign fin         = vld && bus.source_ready && last_out;
    assign rd_addr     = AW'(run) * AW'(STEP) + AW'(idx);
    assign row         = mem[rd_addr[WW-1:0]];

    assign bus.sink_ready     = state == LOAD;
    assign bus.source_valid   = vld;
    assign bus.source_sop     = sop;
    assign bus.source_eop     = eop;
    assign bus.source_channel = ch;
    assign bus.source_data    = dat;
    assign busy               = state != IDLE;

    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = LOAD;
        if (sink_fire && wr_last) state_nx = EMIT;
        if (fin) state_nx = continuous ? LOAD : IDLE;
    end

    always_ff @(posedge clk)
        if (sink_fire) mem[wr_addr] <= bus.sink_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_addr    <= '0;
            run        <= '0;
            chan       <= '0;
            idx        <= '0;
            issued_all <= 1'b0;
            last_out   <= 1'b0;
            vld        <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            ch         <= '0;
            dat        <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= fin;
            if (sink_fire) wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
            if (adv) vld <= !issued_all;
            // All counters wrap back to zero on the final issue, so the next capture starts clean.
            if (issue) begin
                dat        <= row[chan*DATA_WIDTH +: DATA_WIDTH];
                sop        <= idx == '0;
                eop        <= idx_last;
                ch         <= chan;
                last_out   <= final_issue;
                issued_all <= final_issue;
                idx        <= idx_last ? '0 : idx + 1'b1;
                if (idx_last) chan <= chan_last ? '0 : chan + 1'b1;
                if (idx_last && chan_last) run <= run_last ? '0 : run + 1'b1;
            end
            if (fin) issued_all <= 1'b0;
        end
    end
endmodule

// File: doc/multi_channel_batch_buffer.md
# multi_channel_batch_buffer

Captures a fixed-length window of samples from up to `CHANNELS` parallel A2D streams on a single clock. It then replays that window as `RUNS` overlapping batches per channel, each batch shifted by `STEP` samples, to the FFT over a ready/valid streaming interface with backpressure. It sits between the antenna A2D capture path and the FFT core, and supersedes the dual-clock single-channel input buffer with a one-shot or continuous re-arming capture engine.

## Interface
- `BATCH_SIZE`, 2048: entries per output batch, ≥2
- `RUNS`, 3: batches emitted per channel per capture, ≥1
- `STEP`, 1: start-offset increment between successive batches, ≥1
- `CHANNELS`, 2: parallel input channels, ≥1
- `DATA_WIDTH`, 14: bits per entry
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse arming a capture; honoured only in IDLE
- `continuous`  in  1  high: re-arm automatically after EMIT completes; sampled at the end of EMIT
- `sink_valid`  in  1  input sample valid
- `sink_ready`  out  1  high exactly while in LOAD
- `sink_data`  in  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- `source_ready`  in  1  FFT accepts a beat
- `source_valid`  out  1  output beat valid
- `source_sop`  out  1  first beat of a batch
- `source_eop`  out  1  last beat of a batch
- `source_channel`  out  max(1,$clog2(CHANNELS))  channel of the current batch
- `source_data`  out  DATA_WIDTH  output entry
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after the final beat of a capture is accepted

## Operation
- Window length `TOT = BATCH_SIZE + (RUNS-1)*STEP` entries per channel. Storage is `CHANNELS` × `TOT` × `DATA_WIDTH`. The memory has a registered read port.
- States:
  - IDLE → LOAD on `start`.
  - LOAD → EMIT when the TOT-th sample is accepted.
  - EMIT → LOAD on the final accepted beat if `continuous`=1, otherwise EMIT → IDLE.
- LOAD:
  - A sample is written at `wr_addr` on `sink_valid && sink_ready`, for all channels simultaneously.
  - `wr_addr` counts 0…TOT-1.
  - Deasserting `sink_valid` stalls capture without losing position.
- EMIT order is run-major, then channel, then sample:
  - For run r = 0…RUNS-1 and channel c = 0…CHANNELS-1, emit entries r*STEP … r*STEP+BATCH_SIZE-1.
  - Total beats per capture: RUNS*CHANNELS*BATCH_SIZE.
- `source_sop` is asserted on sample index 0 of each batch; `source_eop` on index BATCH_SIZE-1. Both are asserted only together with `source_valid`.
- Counters:
  - `run` is max(1,$clog2(RUNS)) bits.
  - `chan` is max(1,$clog2(CHANNELS)) bits.
  - `idx` is $clog2(BATCH_SIZE) bits.
  - The read address `run*STEP + idx` is computed at $clog2(TOT)+1 bits; it never exceeds TOT-1.
- Ignored events:
  - `start` during LOAD or EMIT is ignored.
  - `sink_valid` outside LOAD is ignored; samples are dropped, since `sink_ready`=0.
- Memory contents are not cleared by reset.

## Timing
- Reset values (immediate, asynchronous):
  - State is IDLE.
  - `sink_ready`, `source_valid`, `source_sop`, `source_eop`, `busy` and `done` are 0.
  - `source_channel` and `source_data` are 0.
  - All counters are 0.
- Reset mid-LOAD or mid-EMIT aborts the capture. No `done` pulse is produced, and the next capture requires a fresh `start`.
- `start` sampled high in cycle N gives `sink_ready`=1 and `busy`=1 from cycle N+1.
- The last LOAD sample accepted in cycle N gives `sink_ready`=0 from N+1. The first `source_valid` appears in cycle N+2, because of the registered memory read.
- Output stage:
  - Once `source_valid` is asserted, `source_data`, `source_sop`, `source_eop` and `source_channel` hold stable until `source_ready`=1.
  - There are no bubbles while `source_ready` stays high: one beat per cycle.
  - `source_valid` never drops without an accepted beat.
- Final beat:
  - The final beat accepted in cycle M gives `done`=1 in M+1 and `source_valid`=0 in M+1.
  - If `continuous`=1 at M, `sink_ready`=1 in M+1; otherwise `busy`=0 in M+1.
- `start` coinciding with `reset` has no effect.

## Test plan
- Parameters for all scenarios: BATCH_SIZE=4, RUNS=3, STEP=2, CHANNELS=2, DATA_WIDTH=8 (TOT=8). Stimulus data: ch0 = i, ch1 = 0x80+i for i=0…7.
- Basic one-shot: `start`, 8 samples, `source_ready`=1 -> 24 beats: 0,1,2,3 | 80–83 | 2–5 | 82–85 | 4–7 | 84–87. SOP/EOP on each 4-beat boundary, `source_channel` alternating 0,1. `done` is high for one cycle, then `busy`=0.
- Backpressure: toggle `source_ready` pseudo-randomly -> identical 24-beat sequence, outputs stable while stalled, no duplicates or drops.
- Sink stalls: drop `sink_valid` for 3 cycles after sample 5 -> captured window still 0…7 and the output matches the basic case. `sink_ready` stays 1 through the stall.
- Continuous mode: `continuous`=1 with a second 8-sample window i+0x10 -> the second 24-beat sequence uses the new data. `busy` never deasserts, and `done` pulses twice.
- Reset mid-EMIT: assert `reset` after beat 10 -> all outputs 0 immediately. Subsequent `start` plus a fresh window yields a correct 24-beat sequence.
- Ignored inputs: `start` pulsed during LOAD and during EMIT, and `sink_valid` high during EMIT -> output sequence unchanged and exactly one `done`.
